program_loader: RTL

- Byte-stream program loader: the writer side of the instruction memory that the fetch unit reads.
- Receives a framed byte stream: sync byte, word count, big-endian instruction words, XOR checksum.
- Assembles 32-bit words and drives the instruction memory write port (writeAddr/writeData/wr) at consecutive word addresses.
- Reports done/error and holds the core in clear while loading.

---
 rtl/program_loader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader driving the instruction memory write port
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 256,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  inData,
  input  logic        inValid,
  output logic        inReady,
  output logic        wr,
  output logic [31:0] writeAddr,
  output logic [31:0] writeData,
  output logic        cpuHold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  errCode,
  output logic [8:0]  wordsWritten
);

  typedef enum logic [2:0] {IDLE, SYNC, COUNT, DATA, WRITE, CHECK, DONE, ERR} state_t;

  localparam logic [9:0] MAX_N = 10'(MAX_WORDS);

  state_t      state, nextState;
  logic [8:0]  wordTarget;
  logic [1:0]  byteCnt;
  logic [7:0]  checksum;
  logic [23:0] shiftReg;
  logic        accept;
  logic        armable;
  logic [8:0]  countN;
  logic        countBad;
  logic [8:0]  wordsNext;

  assign accept    = inValid && inReady;
  assign armable   = (state == IDLE) || (state == DONE) || (state == ERR);
  assign countN    = {1'b0, inData} + 9'd1;
  assign countBad  = {1'b0, countN} > MAX_N;
  assign wordsNext = wordsWritten + 9'd1;

  always_comb begin
    nextState = state;
    inReady   = 1'b0;
    wr        = 1'b0;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) nextState = SYNC;
      end
      SYNC: begin
        inReady = 1'b1;
        if (accept && inData == SYNC_BYTE) nextState = COUNT;
      end
      COUNT: begin
        inReady = 1'b1;
        if (accept) nextState = countBad ? ERR : DATA;
      end
      DATA: begin
        inReady = 1'b1;
        if (accept && byteCnt == 2'd3) nextState = WRITE;
      end
      WRITE: begin
        wr        = 1'b1;
        nextState = (wordsNext == wordTarget) ? CHECK : DATA;
      end
      CHECK: begin
        inReady = 1'b1;
        if (accept) nextState = (inData == checksum) ? DONE : ERR;
      end
      default: nextState = IDLE;
    endcase
  end

  assign cpuHold = !((state == IDLE) || (state == DONE));
  assign busy    = !armable;
  assign done    = (state == DONE);
  assign error   = (state == ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      writeAddr    <= 32'd0;
      writeData    <= 32'd0;
      errCode      <= 2'b00;
      wordsWritten <= 9'd0;
      wordTarget   <= 9'd0;
      byteCnt      <= 2'd0;
      checksum     <= 8'd0;
      shiftReg     <= 24'd0;
    end else begin
      state <= nextState;
      if (armable && start) begin
        errCode      <= 2'b00;
        wordsWritten <= 9'd0;
        checksum     <= 8'd0;
        byteCnt      <= 2'd0;
      end
      if (state == COUNT && accept) begin
        if (countBad) errCode <= 2'b01;
        else          wordTarget <= countN;
      end
      if (state == DATA && accept) begin
        shiftReg <= {shiftReg[15:0], inData};
        checksum <= checksum ^ inData;
        byteCnt  <= byteCnt + 2'd1;
        // Address/data are captured on the 4th byte so they are stable for the whole WRITE cycle.
        if (byteCnt == 2'd3) begin
          writeData <= {shiftReg, inData};
          writeAddr <= BASE_ADDR + {21'd0, wordsWritten, 2'b00};
        end
      end
      if (state == WRITE) wordsWritten <= wordsNext;
      if (state == CHECK && accept && inData != checksum) errCode <= 2'b10;
    end
  end

endmodule
